// File: rtl/ucc_pkg.sv
// Shared types and defaults for the UCC runtime monitor. The SUSP state is
// only present when UCC_IRQ_RESUME_EN is defined.
package ucc_pkg;

  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] PROT_MIN_DEF = 16'h0600;
  localparam logic [ADDR_W-1:0] PROT_MAX_DEF = 16'h07FF;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'hE000;

  localparam logic [2:0] CAUSE_NONE  = 3'd0;
  localparam logic [2:0] CAUSE_WRITE = 3'd1;
  localparam logic [2:0] CAUSE_IRQ   = 3'd2;
  localparam logic [2:0] CAUSE_EXIT  = 3'd3;
  localparam logic [2:0] CAUSE_ENTRY = 3'd4;

`ifdef UCC_IRQ_RESUME_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_VIOL, ST_SUSP} ucc_state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_VIOL} ucc_state_t;
`endif

endpackage

// File: rtl/ucc_range_match.sv
// Combinational compartment lookup: per-compartment hit vector plus the
// lowest-index match and whether pc sits on that compartment's entry point.
module ucc_range_match
  import ucc_pkg::*;
#(
  parameter int N_UCC = 4,
  parameter int IDX_W = 2
) (
  input  logic [ADDR_W-1:0]       pc,
  input  logic [ADDR_W*N_UCC-1:0] ucc_min_bus,
  input  logic [ADDR_W*N_UCC-1:0] ucc_max_bus,
  output logic [N_UCC-1:0]        match_vec,
  output logic                    hit,
  output logic [IDX_W-1:0]        idx,
  output logic                    at_min
);

  logic [N_UCC-1:0] at_min_vec;

  for (genvar k = 0; k < N_UCC; k++) begin : g_cmp
    logic [ADDR_W-1:0] lo;
    logic [ADDR_W-1:0] hi;
    assign lo = ucc_min_bus[k*ADDR_W +: ADDR_W];
    assign hi = ucc_max_bus[k*ADDR_W +: ADDR_W];
    // lo > hi marks a disabled compartment
    assign match_vec[k]  = (lo <= hi) && (pc >= lo) && (pc <= hi);
    assign at_min_vec[k] = (pc == lo);
  end

  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    at_min = 1'b0;
    for (int k = N_UCC - 1; k >= 0; k--) begin
      if (match_vec[k]) begin
        hit    = 1'b1;
        idx    = IDX_W'(k);
        at_min = at_min_vec[k];
      end
    end
  end

endmodule

// File: rtl/ucc_monitor.sv
// UCC runtime monitor: entry/exit/write/irq enforcement, registered outputs one cycle after the
// offending sample; no backpressure. UCC_IRQ_RESUME_EN lets an irq suspend a UCC instead of faulting.
module ucc_monitor
  import ucc_pkg::*;
#(
  parameter int                N_UCC    = 4,
  parameter int                IDX_W    = 2,
  parameter logic [ADDR_W-1:0] PROT_MIN = PROT_MIN_DEF,
  parameter logic [ADDR_W-1:0] PROT_MAX = PROT_MAX_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                    clk,
  input  logic                    puc_rst,
  input  logic [ADDR_W-1:0]       pc,
  input  logic [ADDR_W-1:0]       data_addr,
  input  logic                    data_wr,
  input  logic                    irq,
  input  logic [ADDR_W*N_UCC-1:0] ucc_min_bus,
  input  logic [ADDR_W*N_UCC-1:0] ucc_max_bus,
  output logic                    reset_out,
  output logic                    in_ucc,
  output logic [IDX_W-1:0]        active_ucc,
  output logic [2:0]              viol_cause
);

  ucc_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] prev_pc_q, prev_pc_d;
  logic [2:0]        viol_cause_q, viol_cause_d;
  logic              reset_out_q, reset_out_d;
  logic              in_ucc_q, in_ucc_d;
  logic [IDX_W-1:0]  active_ucc_q, active_ucc_d;

  logic [N_UCC-1:0]  match_vec;
  logic              hit;
  logic [IDX_W-1:0]  m_idx;
  logic              at_min;
  logic              prot_wr;
  logic [ADDR_W-1:0] cur_max;

  ucc_range_match #(.N_UCC(N_UCC), .IDX_W(IDX_W)) u_match (
    .pc          (pc),
    .ucc_min_bus (ucc_min_bus),
    .ucc_max_bus (ucc_max_bus),
    .match_vec   (match_vec),
    .hit         (hit),
    .idx         (m_idx),
    .at_min      (at_min)
  );

  assign prot_wr = data_wr && (data_addr >= PROT_MIN) && (data_addr <= PROT_MAX);
  assign cur_max = ucc_max_bus[idx_q*ADDR_W +: ADDR_W];

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    viol_cause_d = viol_cause_q;
    prev_pc_d    = pc;
    case (state_q)
      ST_IDLE: begin
        if (hit && at_min) begin
          state_d = ST_RUN;
          idx_d   = m_idx;
        end else if (hit) begin
          state_d      = ST_VIOL;
          viol_cause_d = CAUSE_ENTRY;
        end
      end
      ST_RUN: begin
        // checks are ordered by cause priority: WRITE, IRQ, EXIT
        if (prot_wr) begin
          state_d      = ST_VIOL;
          viol_cause_d = CAUSE_WRITE;
        end else if (irq) begin
`ifdef UCC_IRQ_RESUME_EN
          state_d = ST_SUSP;
`else
          state_d      = ST_VIOL;
          viol_cause_d = CAUSE_IRQ;
`endif
        end else if (!match_vec[idx_q]) begin
          if (prev_pc_q == cur_max) begin
            state_d = (hit && at_min) ? ST_RUN : ST_IDLE;
            idx_d   = m_idx;
          end else begin
            state_d      = ST_VIOL;
            viol_cause_d = CAUSE_EXIT;
          end
        end
      end
`ifdef UCC_IRQ_RESUME_EN
      ST_SUSP: begin
        if (match_vec[idx_q]) begin
          state_d = ST_RUN;
        end else if (hit) begin
          state_d      = ST_VIOL;
          viol_cause_d = CAUSE_ENTRY;
        end
      end
`endif
      ST_VIOL: begin
        if (pc == RESET_PC) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    reset_out_d = (state_d == ST_VIOL);
    in_ucc_d    = (state_d == ST_RUN);
`ifdef UCC_IRQ_RESUME_EN
    active_ucc_d = (state_d == ST_RUN || state_d == ST_SUSP) ? idx_d : '0;
`else
    active_ucc_d = (state_d == ST_RUN) ? idx_d : '0;
`endif
  end

  always_ff @(posedge clk or posedge puc_rst) begin
    if (puc_rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      prev_pc_q    <= RESET_PC;
      viol_cause_q <= CAUSE_NONE;
      reset_out_q  <= 1'b0;
      in_ucc_q     <= 1'b0;
      active_ucc_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      prev_pc_q    <= prev_pc_d;
      viol_cause_q <= viol_cause_d;
      reset_out_q  <= reset_out_d;
      in_ucc_q     <= in_ucc_d;
      active_ucc_q <= active_ucc_d;
    end
  end

  assign reset_out  = reset_out_q;
  assign in_ucc     = in_ucc_q;
  assign active_ucc = active_ucc_q;
  assign viol_cause = viol_cause_q;

endmodule
